// File: rtl/pratica2_pkg.sv
// pratica2 shared definitions: word/IR widths, opcodes, sequencer states.
// Also provides a helper that extracts the opcode field of an instruction word.
package pratica2_pkg;

  localparam int WORD_W = 16;
  localparam int IR_W   = 9;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_INS,
    S_LAT_INS,
    S_RD_IMM,
    S_LAT_IMM,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } seq_state_e;

  function automatic logic [2:0] opcode_of(
    input logic [WORD_W-1:0] w
  );
    return w[8:6];
  endfunction

endpackage

// File: rtl/pratica2_seq_wdog.sv
// Instruction watchdog: loaded with TIMEOUT, counts down while enabled.
// Ports: i_clock, i_resetn, i_load (reload), i_en (count), o_trip.
module pratica2_seq_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clock,
  input  logic i_resetn,
  input  logic i_load,
  input  logic i_en,
  output logic o_trip
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Trip on the enabled cycle whose decrement takes the count to 0,
  // i.e. the TIMEOUT-th enabled cycle after a load.
  assign o_trip = i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/pratica2_seq.sv
// pratica2 instruction sequencer: fetch, mvi immediate prefetch, issue, wait.
// Ports: i_clock/i_resetn, i_start/i_stop, memory rd/addr/data, processor
// din/run/done, status pc/busy/halted/err/instr_cnt.
// Option: PRATICA2_SEQ_HALT_OP_EN stops on a fetched OP_HALT word.
module pratica2_seq
  import pratica2_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [WORD_W-1:0] i_mem_data,
  output logic [WORD_W-1:0] o_din,
  output logic              o_run,
  input  logic              i_done,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_err,
  output logic [15:0]       o_instr_cnt
);

  seq_state_e        r_state;
  seq_state_e        w_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] r_ins_q;
  logic [WORD_W-1:0] r_imm_q;
  logic [WORD_W-1:0] w_ins_nxt;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_din;
  logic              r_run;
  logic              r_busy;
  logic              r_halted;
  logic              r_err;
  logic [15:0]       r_instr_cnt;
  logic              w_trip;
  logic              w_is_mvi;
  logic [2:0]        w_lat_op;
  logic              w_retire;

  pratica2_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clock  (i_clock),
    .i_resetn (i_resetn),
    .i_load   (r_state == S_ISSUE),
    .i_en     (r_state == S_EXEC),
    .o_trip   (w_trip)
  );

  assign w_is_mvi = opcode_of(r_ins_q) == OP_MVI;
  assign w_lat_op = opcode_of(i_mem_data);
  assign w_retire = (r_state == S_EXEC) && i_done;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_start && !i_stop) w_nxt = S_RD_INS;
      S_RD_INS:
        w_nxt = S_LAT_INS;
      S_LAT_INS:
        if (w_lat_op == OP_MVI) w_nxt = S_RD_IMM;
`ifdef PRATICA2_SEQ_HALT_OP_EN
        else if (w_lat_op == OP_HALT) w_nxt = S_HALT;
`endif
        else w_nxt = S_ISSUE;
      S_RD_IMM:
        w_nxt = S_LAT_IMM;
      S_LAT_IMM:
        w_nxt = S_ISSUE;
      S_ISSUE:
        w_nxt = S_EXEC;
      S_EXEC:
        // done beats a simultaneous watchdog trip
        if (i_done) w_nxt = i_stop ? S_IDLE : S_RD_INS;
        else if (w_trip) w_nxt = S_HALT;
      S_HALT:
        w_nxt = S_HALT;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  // PC advances past each word as it is latched; wraps modulo 2^ADDR_W.
  always_comb begin
    w_pc_nxt = r_pc;
    if (r_state == S_LAT_INS || r_state == S_LAT_IMM)
      w_pc_nxt = r_pc + ADDR_W'(1);
  end

  assign w_ins_nxt = (r_state == S_LAT_INS) ? i_mem_data : r_ins_q;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ins_q     <= '0;
      r_imm_q     <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_din       <= '0;
      r_run       <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state  <= w_nxt;
      r_pc     <= w_pc_nxt;
      r_ins_q  <= w_ins_nxt;
      if (r_state == S_LAT_IMM) r_imm_q <= i_mem_data;
      r_mem_rd <= (w_nxt == S_RD_INS) || (w_nxt == S_RD_IMM);
      if ((w_nxt == S_RD_INS) || (w_nxt == S_RD_IMM))
        r_mem_addr <= w_pc_nxt;
      if (w_nxt == S_ISSUE)
        r_din <= w_ins_nxt;
      else if (w_nxt == S_EXEC)
        r_din <= w_is_mvi ? r_imm_q : '0;
      else
        r_din <= '0;
      r_run    <= w_nxt == S_ISSUE;
      r_busy   <= (w_nxt != S_IDLE) && (w_nxt != S_HALT);
      r_halted <= w_nxt == S_HALT;
      if ((r_state == S_EXEC) && !i_done && w_trip) r_err <= 1'b1;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign o_mem_rd    = r_mem_rd;
  assign o_mem_addr  = r_mem_addr;
  assign o_din       = r_din;
  assign o_run       = r_run;
  assign o_pc        = r_pc;
  assign o_busy      = r_busy;
  assign o_halted    = r_halted;
  assign o_err       = r_err;
  assign o_instr_cnt = r_instr_cnt;

endmodule
